// File: rtl/hram_wb_arbiter.sv
// rtl/hram_wb_arbiter.sv - round-robin Wishbone arbiter with urgency hint and ack timeout for a HyperRAM slave
module hram_wb_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM*3-1:0]    m_cti_i,
  input  logic [NM*2-1:0]    m_bte_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_urgent_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  output logic [NM-1:0]      grant_o,
  output logic               timeout_o
);

  localparam int SW = DW / 8;
  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX     = CW'(TIMEOUT);
  localparam logic [OW-1:0] LAST_IDX = OW'(NM - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t          state;
  logic [NM-1:0]   grant_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_owner;
  logic [CW-1:0]   cnt;
  logic [NM-1:0]   err_q;
  logic            to_q;
  logic [1:0]      rst_sync;
  logic            arb_en;

  logic [NM-1:0]   urg;
  logic [NM-1:0]   cand;
  logic [OW-1:0]   rr_idx;
  logic [OW-1:0]   pick_idx;
  logic [NM-1:0]   pick_oh;
  logic            pick_ok;
  logic            own_cyc;
  logic            own_stb;
  logic            busy;

  // Reset asserts asynchronously but releases through two flops, so the
  // arbiter never grants on the edge that also sees reset deassert.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arb_en = rst_sync[1];

  // Urgent requesters form their own candidate set; scan starts after last owner.
  always_comb begin
    urg      = m_cyc_i & m_urgent_i;
    cand     = (|urg) ? urg : m_cyc_i;
    rr_idx   = last_owner;
    pick_idx = '0;
    pick_oh  = '0;
    pick_ok  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      rr_idx = (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
      if (!pick_ok && cand[rr_idx]) begin
        pick_idx        = rr_idx;
        pick_oh[rr_idx] = 1'b1;
        pick_ok         = 1'b1;
      end
    end
  end

  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];
  assign busy    = (state == BUSY);

  assign s_adr_o = m_adr_i[owner_q*AW +: AW];
  assign s_dat_o = m_dat_i[owner_q*DW +: DW];
  assign s_sel_o = m_sel_i[owner_q*SW +: SW];
  assign s_cti_o = m_cti_i[owner_q*3 +: 3];
  assign s_bte_o = m_bte_i[owner_q*2 +: 2];
  assign s_we_o  = m_we_i[owner_q];
  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & own_cyc & own_stb;

  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = busy ? (grant_q & {NM{s_ack_i}}) : '0;
  assign m_err_o   = err_q;
  assign grant_o   = grant_q;
  assign timeout_o = to_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      last_owner <= LAST_IDX;
      cnt        <= '0;
      err_q      <= '0;
      to_q       <= 1'b0;
    end else begin
      err_q <= '0;
      to_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && pick_ok) begin
            grant_q <= pick_oh;
            owner_q <= pick_idx;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            grant_q    <= '0;
            last_owner <= owner_q;
            state      <= IDLE;
          end else if (s_ack_i) begin
            cnt <= '0;
          end else if (own_stb) begin
            // A strobe stalled for TIMEOUT cycles is cut off from the slave.
            if (cnt == TMAX) begin
              err_q <= grant_q;
              to_q  <= 1'b1;
              state <= ABORT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            grant_q    <= '0;
            last_owner <= owner_q;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hram_wb_arbiter.sv
// tb/tb_hram_wb_arbiter.sv - directed self-checking bench for hram_wb_arbiter
module tb_hram_wb_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM-1:0]     m_we, m_cyc, m_stb, m_urgent;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack, m_err;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic              s_we, s_cyc, s_stb;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack;
  logic [NM-1:0]     grant;
  logic              timeout;
  logic              auto_ack = 1'b0;
  logic              ack_force = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign s_ack = (auto_ack & s_cyc & s_stb) | ack_force;

  hram_wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_urgent_i(m_urgent),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc got=%b exp=0", s_cyc); end
    total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", m_ack); end
    total++; if (m_err !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", m_err); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin;
    logic [2:0] order [3] = '{3'b000, 3'b000, 3'b000};
    logic [2:0] prev = 3'b000;
    logic [2:0] drop;
    int hold [3] = '{0, 0, 0};
    int n = 0, handoff = 0, adr_bad = 0, stray = 0;
    @(posedge clk); #1;
    auto_ack = 1'b1; m_cyc = 3'b111; m_stb = 3'b111;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drop = 3'b000;
      if (grant != 3'b000 && grant != prev) begin
        if (prev != 3'b000) handoff++;
        if (n < 3) order[n] = grant;
        n++;
      end
      prev = grant;
      if ((m_ack & ~grant) != 3'b000) stray++;
      for (int k = 0; k < NM; k++) begin
        if (grant[k]) begin
          hold[k]++;
          if (s_adr !== m_adr[k*AW +: AW]) adr_bad++;
          if (hold[k] == 4) drop[k] = 1'b1;
        end
      end
      @(posedge clk); #1;
      m_cyc = m_cyc & ~drop; m_stb = m_stb & ~drop;
    end
    total++; if (n != 3) begin bad++; $display("FAIL rr_grant_count got=%0d exp=3", n); end
    total++; if (order[0] !== 3'b001) begin bad++; $display("FAIL rr_first got=%b exp=001", order[0]); end
    total++; if (order[1] !== 3'b010) begin bad++; $display("FAIL rr_second got=%b exp=010", order[1]); end
    total++; if (order[2] !== 3'b100) begin bad++; $display("FAIL rr_third got=%b exp=100", order[2]); end
    total++; if (handoff != 0) begin bad++; $display("FAIL rr_idle_gap got=%0d direct handoffs exp=0", handoff); end
    total++; if (adr_bad != 0) begin bad++; $display("FAIL rr_adr_mux got=%0d bad cycles exp=0", adr_bad); end
    total++; if (stray != 0) begin bad++; $display("FAIL rr_stray_ack got=%0d exp=0", stray); end
    auto_ack = 1'b0;
  endtask

  task automatic test_urgent_burst;
    logic [2:0] order [3] = '{3'b000, 3'b000, 3'b000};
    logic [2:0] prev = 3'b000;
    logic [2:0] drop;
    int n = 0, acks = 0, held_bad = 0;
    bit got0 = 1'b0, urg_up = 1'b0, raise;
    @(posedge clk); #1;
    auto_ack = 1'b1; m_cti[2:0] = 3'b010; m_cyc = 3'b011; m_stb = 3'b011;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drop = 3'b000;
      if (grant != 3'b000 && grant != prev) begin
        if (n < 3) order[n] = grant;
        n++;
      end
      prev = grant;
      if (grant === 3'b001) got0 = 1'b1;
      if (got0 && m_cyc[0] && grant !== 3'b001) held_bad++;
      if (m_ack[0]) acks++;
      raise = (acks == 3) && !urg_up;
      if (m_ack[0] && acks == 8) drop[0] = 1'b1;
      if (m_ack[1]) drop[1] = 1'b1;
      if (m_ack[2]) drop[2] = 1'b1;
      @(posedge clk); #1;
      if (raise) begin m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_urgent[2] = 1'b1; urg_up = 1'b1; end
      if (acks == 7) m_cti[2:0] = 3'b111;
      m_cyc = m_cyc & ~drop; m_stb = m_stb & ~drop; m_urgent = m_urgent & ~drop;
    end
    m_cti[2:0] = 3'b000;
    total++; if (acks != 8) begin bad++; $display("FAIL burst_acks got=%0d exp=8", acks); end
    total++; if (held_bad != 0) begin bad++; $display("FAIL burst_preempt got=%0d exp=0", held_bad); end
    total++; if (order[0] !== 3'b001) begin bad++; $display("FAIL burst_first got=%b exp=001", order[0]); end
    total++; if (order[1] !== 3'b100) begin bad++; $display("FAIL burst_urgent_next got=%b exp=100", order[1]); end
    total++; if (order[2] !== 3'b010) begin bad++; $display("FAIL burst_last got=%b exp=010", order[2]); end
    auto_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int w = 0, first = -1, errn = 0, ton = 0, other = 0;
    logic scyc17 = 1'b1;
    logic [2:0] g_held;
    @(posedge clk); #1;
    auto_ack = 1'b0; m_cyc = 3'b010; m_stb = 3'b010;
    @(negedge clk);
    while (grant !== 3'b010 && w < 10) begin @(negedge clk); w++; end
    for (int k = 0; k < 23; k++) begin
      if (k != 0) @(negedge clk);
      if (m_err[1]) begin if (first < 0) first = k; errn++; end
      if (timeout) ton++;
      if (m_err[0] | m_err[2]) other++;
      if (k == 17) scyc17 = s_cyc;
    end
    g_held = grant;
    @(posedge clk); #1;
    m_cyc = 3'b000; m_stb = 3'b000;
    @(posedge clk);
    @(negedge clk);
    total++; if (first != 17) begin bad++; $display("FAIL to_err_cycle got=%0d exp=17", first); end
    total++; if (errn != 1) begin bad++; $display("FAIL to_err_width got=%0d exp=1", errn); end
    total++; if (ton != 1) begin bad++; $display("FAIL to_pulse_width got=%0d exp=1", ton); end
    total++; if (scyc17 !== 1'b0) begin bad++; $display("FAIL to_s_cyc got=%b exp=0", scyc17); end
    total++; if (other != 0) begin bad++; $display("FAIL to_other_err got=%0d exp=0", other); end
    total++; if (g_held !== 3'b010) begin bad++; $display("FAIL to_grant_held got=%b exp=010", g_held); end
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL to_grant_clear got=%b exp=000", grant); end
  endtask

  task automatic test_ack_at_limit;
    int w = 0, errs = 0, tos = 0;
    logic ack16 = 1'b0, cyc16 = 1'b0;
    @(posedge clk); #1;
    auto_ack = 1'b0; m_cyc = 3'b001; m_stb = 3'b001;
    @(negedge clk);
    while (grant !== 3'b001 && w < 10) begin @(negedge clk); w++; end
    for (int k = 0; k < 21; k++) begin
      if (k != 0) @(negedge clk);
      if (m_err != 3'b000) errs++;
      if (timeout) tos++;
      if (k == 16) begin ack16 = m_ack[0]; cyc16 = s_cyc; end
      if (k == 15) begin @(posedge clk); #1; ack_force = 1'b1; end
      if (k == 16) begin @(posedge clk); #1; ack_force = 1'b0; m_cyc = 3'b000; m_stb = 3'b000; end
    end
    total++; if (ack16 !== 1'b1) begin bad++; $display("FAIL limit_ack got=%b exp=1", ack16); end
    total++; if (cyc16 !== 1'b1) begin bad++; $display("FAIL limit_s_cyc got=%b exp=1", cyc16); end
    total++; if (errs != 0) begin bad++; $display("FAIL limit_err got=%0d exp=0", errs); end
    total++; if (tos != 0) begin bad++; $display("FAIL limit_timeout got=%0d exp=0", tos); end
  endtask

  task automatic test_reset_mid;
    int w = 0, edges = 1;
    @(posedge clk); #1;
    auto_ack = 1'b1; m_cyc = 3'b100; m_stb = 3'b100;
    @(negedge clk);
    while (grant !== 3'b100 && w < 8) begin @(negedge clk); w++; end
    total++; if (s_cyc !== 1'b1 || m_ack !== 3'b100) begin bad++; $display("FAIL mid_active got=%b/%b exp=1/100", s_cyc, m_ack); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL mid_rst_grant got=%b exp=000", grant); end
    total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL mid_rst_s_cyc got=%b exp=0", s_cyc); end
    total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL mid_rst_ack got=%b exp=000", m_ack); end
    m_cyc = 3'b111; m_stb = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    while (grant === 3'b000 && edges < 10) begin @(negedge clk); edges++; end
    total++; if (edges < 2) begin bad++; $display("FAIL mid_release_latency got=%0d edges exp>=2", edges); end
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL mid_first_winner got=%b exp=001", grant); end
    @(posedge clk); #1;
    m_cyc = 3'b000; m_stb = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    auto_ack = 1'b0;
  endtask

  task automatic test_single_requester;
    int w, other = 0, granted = 0;
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      m_cyc = 3'b010; m_stb = 3'b010;
      w = 0;
      @(negedge clk);
      if ((m_ack[0] | m_ack[2] | m_err[0] | m_err[2]) != 1'b0) other++;
      while (grant !== 3'b010 && w < 6) begin
        @(negedge clk); w++;
        if ((m_ack[0] | m_ack[2] | m_err[0] | m_err[2]) != 1'b0) other++;
      end
      total++;
      if (grant !== 3'b010 || m_ack !== 3'b010) begin
        bad++; $display("FAIL single_grant%0d got=%b/%b exp=010/010", i, grant, m_ack);
      end else granted++;
      @(posedge clk); #1;
      m_cyc = 3'b000; m_stb = 3'b000;
      repeat (2) begin
        @(negedge clk);
        if ((m_ack[0] | m_ack[2] | m_err[0] | m_err[2]) != 1'b0) other++;
      end
    end
    total++; if (granted != 5) begin bad++; $display("FAIL single_count got=%0d exp=5", granted); end
    total++; if (other != 0) begin bad++; $display("FAIL single_others got=%0d exp=0", other); end
    auto_ack = 1'b0;
  endtask

  initial begin
    m_adr    = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    m_dat    = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    m_sel    = '1;
    m_cti    = '0;
    m_bte    = '0;
    m_we     = '0;
    m_cyc    = '0;
    m_stb    = '0;
    m_urgent = '0;
    s_dat_i  = 32'h5A5A_1234;
    test_reset();
    test_round_robin();
    test_urgent_burst();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    test_single_requester();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
